dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised multi-stage register pipeline for the ECE251 datapath catalog. It generalises the single N-bit D flip-flop with complement output to DEPTH stages. Each stage has a valid bit, a common advance enable, a flush, and an occupancy count. It sits between datapath stages wherever a fixed-latency, stallable delay line is needed, for example the pipeline registers of the multi-cycle CPU. With DEPTH = 1 it behaves as an enabled DFF with a valid flag.

## Interface
- N, 32, data width in bits (≥ 1)
- DEPTH, 4, number of register stages (≥ 1)
- RST_VAL, '0, N-bit value loaded into every stage's data on reset
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous and active-high
- en  in  1  advance enable; 1 shifts the pipeline one stage, 0 holds all state
- flush  in  1  synchronous invalidate of all stages
- d  in  N  data into stage 0
- valid_in  in  1  qualifies d; captured into stage 0's valid bit when en = 1
- q  out  N  data of the last stage, DEPTH-1
- qn  out  N  bitwise complement of q
- valid_out  out  1  valid bit of the last stage
- count  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
Priority is evaluated on each rising clk edge, highest first:
- **rst = 1:**
  - every stage data = RST_VAL
  - every valid bit = 0
  - count = 0
  - en and flush are ignored
- **flush = 1:**
  - all valid bits = 0 and count = 0
  - stage data is held, not cleared
  - en is ignored, so no shift happens on a flush cycle
- **en = 1:**
  - stage[i] ← stage[i-1] for i = 1..DEPTH-1, covering both data and valid
  - stage[0].data ← d and stage[0].valid ← valid_in
  - count ← count + valid_in − valid[DEPTH-1]
- **Otherwise:** all state holds.

Rules that apply in every cycle:
- Invalid entries still shift their data, so q follows the pipeline even when valid_out = 0.
- q, qn and valid_out are driven directly from stage DEPTH-1 registers. There is no combinational path from d, valid_in or en to any output.
- qn = ~q at all times, including during and after reset.
- count never exceeds DEPTH and never underflows. It equals the popcount of the valid bits; verification checks this as an invariant every cycle.
- Full condition (count = DEPTH) with en = 1 and valid_in = 1: count stays DEPTH while entries stream out in order. The block has no backpressure output; the producer owns stalling via en.

## Timing
- Latency is DEPTH enabled edges from d/valid_in to q/valid_out. Cycles with en = 0 add delay one for one.
- Output values after reset:
  - q = RST_VAL
  - qn = ~RST_VAL
  - valid_out = 0
  - count = 0
- After a flush: valid_out = 0 and count = 0 on the edge where flush is sampled. q keeps its previous value.
- Reset or flush asserted mid-operation takes effect on that edge. Any entries in flight are lost.
- If rst and flush are both asserted, rst wins.
- If flush and en are both asserted, flush wins and d is not captured.

## Structure
- Shared package dff_pipe_pkg holds:
  - the count-width localparam, computed from DEPTH via $clog2(DEPTH+1)
  - a packed struct stage_t with fields data [N-1:0] and valid
- Sub-module dffe_stage:
  - one N+1-bit register with sync reset, flush (clears valid only) and enable
  - instantiated DEPTH times in a generate loop
- The count register and the qn inversion live in the top level.

## Test plan
Parameters for all scenarios: N = 32, DEPTH = 4, RST_VAL = 0.
1. Assert rst for one edge with en = 1, valid_in = 1, d = 0xFFFF_FFFF → q = 0x0000_0000, qn = 0xFFFF_FFFF, valid_out = 0, count = 0.
2. With en = 1, present d = 0x0000_0001 with valid_in = 1 for one edge, then valid_in = 0 → on the 4th edge valid_out = 1, q = 0x0000_0001, qn = 0xFFFF_FFFE. count reads 1, 1, 1, then 0 after the 5th edge.
3. Repeat scenario 2 but drop en for 3 cycles after the 2nd edge → q, valid_out and count frozen during the stall; valid_out rises on the 7th edge.
4. Apply d = 1, 2, 3, 4, 5, 6 with valid_in = 1 on consecutive enabled edges → count = 4 after edge 4 and stays 4; q reads 1, 2, 3 on edges 4, 5, 6 in order.
5. Fill with 4 valid entries, then assert flush together with en = 1 and d = 0xA5A5_A5A5 → next cycle count = 0, valid_out = 0, q unchanged. 0xA5A5_A5A5 never appears at q with valid_out = 1.
6. With the pipeline full, assert rst together with flush = 1 and en = 1 → reset values as in scenario 1. On the next enabled edge with valid_in = 1, count = 1.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared definitions for the dff_pipe register pipeline.
//   count_width() - width of the occupancy counter for a given depth
//   stage_t       - one pipeline stage (data + valid) at the catalog default width
package dff_pipe_pkg;

    localparam int unsigned DEF_N     = 32;
    localparam int unsigned DEF_DEPTH = 4;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 values.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned CNT_W = count_width(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_N-1:0] data;
        logic             valid;
    } stage_t;

endpackage

// File: rtl/dff_pipe_dffe_stage.sv
// dffe_stage: one N+1-bit pipeline register (data + valid).
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset: data <= RST_VAL, valid <= 0
//   flush    - clears valid only; data holds; beats en
//   en       - load d/valid_in
//   d        - data in
//   valid_in - valid in
//   q        - registered data
//   valid    - registered valid
module dffe_stage #(
    parameter int unsigned       N       = 32,
    parameter logic [N-1:0]      RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [N-1:0] d,
    input  logic         valid_in,
    output logic [N-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            q     <= d;
            valid <= valid_in;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage stallable register pipeline with valid bits,
// flush and occupancy count.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset (highest priority)
//   en        - advance the whole pipeline by one stage
//   flush     - invalidate every stage (data held, no shift)
//   d         - data into stage 0
//   valid_in  - qualifies d
//   q         - data of the last stage
//   qn        - ~q
//   valid_out - valid bit of the last stage
//   count     - number of valid stages, 0..DEPTH
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned  N       = 32,
    parameter int unsigned  DEPTH   = 4,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [N-1:0]                 d,
    input  logic                         valid_in,
    output logic [N-1:0]                 q,
    output logic [N-1:0]                 qn,
    output logic                         valid_out,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned CW = count_width(DEPTH);

    logic [N-1:0] stage_data  [DEPTH];
    logic         stage_valid [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [N-1:0] in_data;
        logic         in_valid;

        if (i == 0) begin : g_head
            assign in_data  = d;
            assign in_valid = valid_in;
        end else begin : g_body
            assign in_data  = stage_data[i-1];
            assign in_valid = stage_valid[i-1];
        end

        dffe_stage #(
            .N       (N),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .flush    (flush),
            .d        (in_data),
            .valid_in (in_valid),
            .q        (stage_data[i]),
            .valid    (stage_valid[i])
        );
    end

    // Tracked incrementally rather than by popcount: one entry enters at
    // stage 0 and one leaves from the last stage on each enabled edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(valid_in) - CW'(stage_valid[DEPTH-1]);
        end
    end

    assign q         = stage_data[DEPTH-1];
    assign qn        = ~stage_data[DEPTH-1];
    assign valid_out = stage_valid[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  d = '0;
    logic          valid_in = 1'b0;
    logic [N-1:0]  q, qn;
    logic          valid_out;
    logic [2:0]    count;

    dff_pipe #(
        .N       (N),
        .DEPTH   (DEPTH),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .valid_in  (valid_in),
        .q         (q),
        .qn        (qn),
        .valid_out (valid_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pipeline as a plain array of (data, valid) slots,
    // index 0 = newest; occupancy is simply how many slots are valid.
    logic [N-1:0] m_data  [DEPTH];
    bit           m_valid [DEPTH];
    bit           model_live = 0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic model_edge(input bit r, input bit f, input bit e,
                              input logic [N-1:0] din, input bit vin);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i]  = '0;
                m_valid[i] = 0;
            end
            model_live = 1;
        end else if (f) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else if (e) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                m_data[i]  = m_data[i-1];
                m_valid[i] = m_valid[i-1];
            end
            m_data[0]  = din;
            m_valid[0] = vin;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("model_q",         q,                  m_data[DEPTH-1]);
            chk("model_qn",        qn,                 ~m_data[DEPTH-1]);
            chk("model_valid_out", {31'b0, valid_out}, {31'b0, m_valid[DEPTH-1]});
            chk("model_count",     {29'b0, count},     32'(m_count()));
            chk("qn_is_not_q",     qn,                 ~q);
        end
    end

    // One clock edge with the given inputs; returns 1 time unit after the
    // following falling edge so literal checks don't race the compare block.
    task automatic step(input bit r, input bit f, input bit e,
                        input logic [N-1:0] din, input bit vin);
        rst = r; flush = f; en = e; d = din; valid_in = vin;
        @(posedge clk);
        model_edge(r, f, e, din, vin);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 1, 32'hFFFF_FFFF, 1);
    endtask

    initial begin
        @(negedge clk);

        // 1: reset with en/valid_in/d active
        do_reset();
        chk("s1_q",     q,                  32'h0000_0000);
        chk("s1_qn",    qn,                 32'hFFFF_FFFF);
        chk("s1_valid", {31'b0, valid_out}, 32'd0);
        chk("s1_count", {29'b0, count},     32'd0);

        // 2: single token, latency of DEPTH enabled edges
        step(0, 0, 1, 32'h1, 1);
        chk("s2_count_e1", {29'b0, count}, 32'd1);
        step(0, 0, 1, 32'h0, 0);
        step(0, 0, 1, 32'h0, 0);
        chk("s2_valid_e3", {31'b0, valid_out}, 32'd0);
        step(0, 0, 1, 32'h0, 0);
        chk("s2_q_e4",     q,                  32'h0000_0001);
        chk("s2_qn_e4",    qn,                 32'hFFFF_FFFE);
        chk("s2_valid_e4", {31'b0, valid_out}, 32'd1);
        chk("s2_count_e4", {29'b0, count},     32'd1);
        step(0, 0, 1, 32'h0, 0);
        chk("s2_count_e5", {29'b0, count},     32'd0);
        chk("s2_valid_e5", {31'b0, valid_out}, 32'd0);

        // 3: stall of 3 cycles after the 2nd edge
        do_reset();
        step(0, 0, 1, 32'h1, 1);
        step(0, 0, 1, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'hDEAD_BEEF, 1);
            chk("s3_stall_valid", {31'b0, valid_out}, 32'd0);
            chk("s3_stall_count", {29'b0, count},     32'd1);
            chk("s3_stall_q",     q,                  32'd0);
        end
        step(0, 0, 1, 32'h0, 0);
        chk("s3_valid_e6", {31'b0, valid_out}, 32'd0);
        step(0, 0, 1, 32'h0, 0);
        chk("s3_valid_e7", {31'b0, valid_out}, 32'd1);
        chk("s3_q_e7",     q,                  32'd1);

        // 4: streaming while full
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1, 32'(i), 1);
            if (i >= 4) begin
                chk("s4_count_full", {29'b0, count}, 32'd4);
                chk("s4_q_order",    q,              32'(i - 3));
                chk("s4_valid",      {31'b0, valid_out}, 32'd1);
            end
        end

        // 5: flush beats en; d is not captured, q holds
        step(0, 1, 1, 32'hA5A5_A5A5, 1);
        chk("s5_count", {29'b0, count},     32'd0);
        chk("s5_valid", {31'b0, valid_out}, 32'd0);
        chk("s5_q",     q,                  32'd3);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 0, 1, 32'h0, 0);
            chk("s5_no_a5", {31'b0, (valid_out && q == 32'hA5A5_A5A5)}, 32'd0);
        end

        // 6: reset beats flush and en while full
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'(100 + i), 1);
        chk("s6_full", {29'b0, count}, 32'd4);
        step(1, 1, 1, 32'hFFFF_FFFF, 1);
        chk("s6_q",     q,                  32'h0000_0000);
        chk("s6_qn",    qn,                 32'hFFFF_FFFF);
        chk("s6_valid", {31'b0, valid_out}, 32'd0);
        chk("s6_count", {29'b0, count},     32'd0);
        step(0, 0, 1, 32'h1234_5678, 1);
        chk("s6_count_after", {29'b0, count}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 75),
                 N'($urandom),
                 1'($urandom));
            if (count > 3'(DEPTH)) chk("count_bound", {29'b0, count}, 32'(DEPTH));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
